// File: rtl/la_capture_if.sv
// Control, trigger-configuration and readback signals of the logic-analyser capture core.
// The host or register block drives the master side, and the core drives the slave side.
interface la_capture_if #(
  parameter int DATA_W = 49,
  parameter int AW     = 10,
  parameter int CNT_W  = 8
);
  logic              sample_en;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic              trig_edge;
  logic [CNT_W-1:0]  trig_count;
  logic [AW-1:0]     pretrig_len;
  logic              arm;
  logic              abort;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output sample_en, data_i, trig_mask, trig_value, trig_edge, trig_count,
           pretrig_len, arm, abort, rd_addr,
    input  state_o, triggered_o, done_o, rd_data
  );

  modport slave (
    input  sample_en, data_i, trig_mask, trig_value, trig_edge, trig_count,
           pretrig_len, arm, abort, rd_addr,
    output state_o, triggered_o, done_o, rd_data
  );
endinterface

// File: rtl/la_capture_core.sv
// Capture engine: writes probe words into a circular buffer, fires on a mask/value trigger,
// and returns the captured window in chronological order, with index 0 holding the oldest sample.
module la_capture_core #(
  parameter int DATA_W = 49,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  la_capture_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] cfg_mask;
  logic [DATA_W-1:0] cfg_value;
  logic              cfg_edge;
  logic [CNT_W-1:0]  cfg_count;
  logic [AW-1:0]     cfg_pre;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     pre_cnt;
  logic [CNT_W-1:0]  occ;
  logic [AW-1:0]     post_rem;
  logic [AW-1:0]     trig_ptr;
  logic              match_q;
  logic              triggered_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          active;
  logic          wr_en;
  logic          match;
  logic          hit;
  logic [AW-1:0] post_len;
  logic [AW-1:0] rd_ptr;

  assign active   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign wr_en    = active && bus.sample_en && !bus.abort;
  assign match    = ((bus.data_i ^ cfg_value) & cfg_mask) == '0;
  assign hit      = cfg_edge ? (match && !match_q) : match;
  assign post_len = LAST_IDX - cfg_pre;
  // Pointer arithmetic wraps naturally at AW bits because DEPTH is a power of two.
  assign rd_ptr   = trig_ptr - cfg_pre + bus.rd_addr;

  // NOTE: the sample RAM has no reset so it maps onto block RAM; only the control state is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= bus.data_i;
  end

  // NOTE: every register below uses non-blocking assignment, so all of them update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cfg_mask    <= '0;
      cfg_value   <= '0;
      cfg_edge    <= 1'b0;
      cfg_count   <= CNT_W'(1);
      cfg_pre     <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      occ         <= '0;
      post_rem    <= '0;
      trig_ptr    <= '0;
      match_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_data_q <= mem[rd_ptr];
      if (bus.abort) begin
        state       <= S_IDLE;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
      end else if (bus.arm && (state == S_IDLE || state == S_DONE)) begin
        cfg_mask    <= bus.trig_mask;
        cfg_value   <= bus.trig_value;
        cfg_edge    <= bus.trig_edge;
        cfg_count   <= (bus.trig_count == '0) ? CNT_W'(1) : bus.trig_count;
        // The AW-bit port cannot carry a value above DEPTH-1, so the value needs no clamping.
        cfg_pre     <= bus.pretrig_len;
        wr_ptr      <= '0;
        pre_cnt     <= '0;
        occ         <= '0;
        post_rem    <= '0;
        match_q     <= 1'b0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
        state       <= (bus.pretrig_len == '0) ? S_ARMED : S_PRE;
      end else if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        match_q <= match;
        case (state)
          S_PRE: begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == cfg_pre - 1'b1) state <= S_ARMED;
          end
          S_ARMED: begin
            if (hit) begin
              occ <= occ + 1'b1;
              if (occ == cfg_count - 1'b1) begin
                trig_ptr    <= wr_ptr;
                post_rem    <= post_len;
                triggered_q <= 1'b1;
                if (post_len == '0) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= S_POST;
                end
              end
            end
          end
          S_POST: begin
            post_rem <= post_rem - 1'b1;
            if (post_rem == AW'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.state_o     = state;
  assign bus.triggered_o = triggered_q;
  assign bus.done_o      = done_q;
  assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_la_capture_core.sv
// Scoreboard bench for la_capture_core with DEPTH=16 and DATA_W=8: it runs the capture scenarios
// and queues the expected readback words, which are compared when rd_data returns.
module tb_la_capture_core;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  la_capture_if #(.DATA_W(DATA_W), .AW(AW), .CNT_W(CNT_W)) bus ();

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] hist  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] gen(input int mode, input int idx);
    if (mode == 2) return ((idx % 12) < 6) ? 8'h55 : 8'h00;
    return DATA_W'(idx);
  endfunction

  task automatic do_arm(input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] value,
                        input logic edge_md, input logic [CNT_W-1:0] count,
                        input logic [AW-1:0] pre, input string tag);
    bus.trig_mask   = mask;
    bus.trig_value  = value;
    bus.trig_edge   = edge_md;
    bus.trig_count  = count;
    bus.pretrig_len = pre;
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
    // Scramble the configuration inputs because the core must use the values latched at arm.
    bus.trig_value  = ~value;
    bus.trig_mask   = '1;
    bus.trig_edge   = ~edge_md;
    bus.trig_count  = count + 8'd3;
    bus.pretrig_len = pre + 4'd5;
    check({tag, " arm_state"}, 32'(bus.state_o), (pre == '0) ? 32'd2 : 32'd1);
  endtask

  // mode 0: counter per sample, 1: counter per cycle with sample_en on even cycles, 2: held 0x55/0x00 runs
  task automatic run_capture(input string tag, input int mode,
                             input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] value,
                             input logic edge_md, input logic [CNT_W-1:0] count,
                             input logic [AW-1:0] pre, input int exp_trig, input int exp_p);
    int  sidx;
    int  trig_at;
    int  cyc;
    int  idx;
    bit  fin;
    bit  en;
    sidx = 0; trig_at = -1; cyc = 0; fin = 1'b0;
    hist.delete();
    do_arm(mask, value, edge_md, count, pre, tag);
    while (!fin && cyc < 400) begin
      en = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      bus.sample_en = en;
      bus.data_i    = (mode == 1) ? DATA_W'(cyc) : gen(mode, sidx);
      bus.arm       = (cyc == 2);
      step();
      bus.arm = 1'b0;
      if (en) begin
        hist.push_back(bus.data_i);
        sidx++;
      end
      if (bus.triggered_o && trig_at < 0) trig_at = sidx - 1;
      if (bus.done_o) fin = 1'b1;
      cyc++;
    end
    bus.sample_en = 1'b0;
    check({tag, " done_seen"}, 32'(fin), 32'd1);
    check({tag, " trig_sample"}, 32'(trig_at), 32'(exp_trig));
    check({tag, " samples_to_done"}, 32'(sidx), 32'(exp_trig + DEPTH - exp_p));
    check({tag, " done_state"}, 32'(bus.state_o), 32'd4);
    if (fin) begin
      for (int i = 0; i < DEPTH; i++) begin
        bus.rd_addr = AW'(i);
        idx = exp_trig - exp_p + i;
        exp_q.push_back((idx >= 0 && idx < hist.size()) ? hist[idx] : 8'hEE);
        step();
        check($sformatf("%s rd[%0d]", tag, i), 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.sample_en = 1'b0; bus.data_i = '0; bus.arm = 1'b0; bus.abort = 1'b0; bus.rd_addr = '0;
    bus.trig_mask = '0; bus.trig_value = '0; bus.trig_edge = 1'b0; bus.trig_count = '0;
    bus.pretrig_len = '0;
    step(); step();
    rst = 1'b0;
    check("reset state", 32'(bus.state_o), 32'd0);
    check("reset triggered", 32'(bus.triggered_o), 32'd0);
    check("reset done", 32'(bus.done_o), 32'd0);
    check("reset rd_data", 32'(bus.rd_data), 32'd0);

    run_capture("level",   0, 8'hFF, 8'h20, 1'b0, 8'd1, 4'd4,  32, 4);
    run_capture("nth",     0, 8'h0F, 8'h01, 1'b0, 8'd2, 4'd4,  33, 4);
    run_capture("edge",    2, 8'hFF, 8'h55, 1'b1, 8'd2, 4'd0,  12, 0);
    run_capture("lvlhold", 2, 8'hFF, 8'h55, 1'b0, 8'd2, 4'd0,   1, 0);
    run_capture("gaps",    1, 8'hFF, 8'h20, 1'b0, 8'd1, 4'd4,  16, 4);
    run_capture("pre0",    0, 8'hFF, 8'h20, 1'b0, 8'd1, 4'd0,  32, 0);
    run_capture("pre15",   0, 8'hFF, 8'h20, 1'b0, 8'd1, 4'd15, 32, 15);
    run_capture("clamp",   0, 8'hFF, 8'h20, 1'b0, 8'd1, '1,    32, 15);
    run_capture("cnt0",    0, 8'hFF, 8'h20, 1'b0, 8'd0, 4'd4,  32, 4);

    // Abort while in POST
    do_arm(8'hFF, 8'h20, 1'b0, 8'd1, 4'd4, "abort");
    guard = 0;
    while (!bus.triggered_o && guard < 100) begin
      bus.sample_en = 1'b1;
      bus.data_i    = DATA_W'(guard);
      step();
      guard++;
    end
    check("abort reached_post", 32'(bus.state_o), 32'd3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.sample_en = 1'b0;
    check("abort state", 32'(bus.state_o), 32'd0);
    check("abort done", 32'(bus.done_o), 32'd0);
    check("abort triggered", 32'(bus.triggered_o), 32'd0);

    // arm and abort in the same cycle: abort wins
    bus.trig_mask = 8'hFF; bus.trig_value = 8'h20; bus.trig_count = 8'd1; bus.pretrig_len = 4'd4;
    bus.arm = 1'b1; bus.abort = 1'b1;
    step();
    bus.arm = 1'b0; bus.abort = 1'b0;
    check("arm+abort state", 32'(bus.state_o), 32'd0);
    step();
    check("arm+abort stays", 32'(bus.state_o), 32'd0);

    // Reset while in ARMED, then re-run scenario 1
    do_arm(8'hFF, 8'h20, 1'b0, 8'd1, 4'd4, "rst");
    for (int i = 0; i < 6; i++) begin
      bus.sample_en = 1'b1;
      bus.data_i    = DATA_W'(i);
      step();
    end
    bus.sample_en = 1'b0;
    check("rst armed", 32'(bus.state_o), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst state", 32'(bus.state_o), 32'd0);
    check("rst rd_data", 32'(bus.rd_data), 32'd0);
    run_capture("rerun", 0, 8'hFF, 8'h20, 1'b0, 8'd1, 4'd4, 32, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised on-chip capture engine; successor to the fixed-width GAO probe on the pixel path (R/G/B, light, index).
- Records DATA_W-bit probe words into a DEPTH-deep circular buffer.
- Programmable mask/value trigger with level or edge mode, Nth-occurrence qualification and runtime pre-trigger length.
- Captured window read back in chronological order by a host or register interface.

Parameters:
- DATA_W, 49, probe word width (R,G,B,light,index = 8+8+8+16+9).
- DEPTH, 1024, buffer depth in samples; power of two, minimum 4.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- CNT_W, 8, width of the trigger occurrence counter.

Ports:
- clk_i  in  1  capture clock (pclk domain); all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- sample_en  in  1  qualifies data_i this cycle; nothing advances when low.
- data_i  in  DATA_W  probe word.
- trig_mask  in  DATA_W  bit compare enable; 1 = compare.
- trig_value  in  DATA_W  compare value.
- trig_edge  in  1  0 = level match, 1 = rising-edge-of-match.
- trig_count  in  CNT_W  fire on this occurrence; 0 treated as 1.
- pretrig_len  in  AW  samples kept before trigger; values above DEPTH-1 clamp to DEPTH-1.
- arm  in  1  single-cycle start pulse.
- abort  in  1  single-cycle stop pulse.
- state_o  out  3  0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 DONE.
- triggered_o  out  1  high in POST and DONE.
- done_o  out  1  high in DONE.
- rd_addr  in  AW  logical sample index; 0 = oldest.
- rd_data  out  DATA_W  sample at rd_addr; one cycle latency.

Behaviour:
- Reset: state IDLE; triggered_o, done_o = 0; rd_data = 0; write pointer, pre/post/occurrence counters and match_q cleared. Buffer RAM contents are not cleared.
- Configuration (trig_*, pretrig_len clamped) latched on arm. Changes after arm are ignored until the next arm.
- A sampled cycle is a cycle with sample_en = 1.
- Buffer write, PRE/ARMED/POST only:
  - every sampled cycle writes data_i to mem[wr_ptr];
  - wr_ptr increments modulo DEPTH (wrap is normal).
- match = ((data_i ^ value) & mask) == 0.
  - match_q updates on sampled cycles only; cleared on arm.
  - hit = match in level mode; match & ~match_q in edge mode.
- IDLE:
  - arm -> PRE, wr_ptr = 0, counters cleared.
  - If latched pretrig_len = 0 -> ARMED directly.
- PRE:
  - counts sampled cycles; after pretrig_len samples -> ARMED.
  - hits ignored; match_q still tracks.
- ARMED:
  - each sampled hit increments occ.
  - When occ reaches trig_count (that sample included) -> POST.
  - trig_ptr = address written that cycle; post_rem = DEPTH-1-pretrig_len.
  - If post_rem = 0 -> DONE directly.
- POST:
  - each sampled cycle decrements post_rem.
  - On the sample making it 0 -> DONE; that write completes.
  - No further writes in DONE.
- DONE:
  - start_ptr = trig_ptr - pretrig_len mod DEPTH.
  - Trigger sample sits at logical index pretrig_len.
  - rd_data <= mem[(start_ptr + rd_addr) mod DEPTH], registered; readable in any state, meaningful only in DONE.
  - arm -> restarts capture as from IDLE.
- abort:
  - any state -> IDLE next cycle; flags drop.
  - abort and arm in the same cycle: abort wins.
- arm while in PRE/ARMED/POST is ignored.
- rst_i mid-capture: as reset; the next arm starts cleanly.
- If the trigger arrives before the buffer has wrapped, logical indices 0..pretrig_len-1 still hold only the pretrig_len pre samples. No stale-data flagging.

Test Plan:
DEPTH=16, DATA_W=8, data_i = incrementing counter from 0x00 on the first sampled cycle after arm, sample_en=1 unless stated.
1. Level trigger: mask 0xFF, value 0x20, count 1, pretrig 4 -> POST entered on 0x20; DONE after 0x2B written; rd_addr 0..15 returns 0x1C..0x2B, latency 1 cycle.
2. Nth occurrence plus PRE masking: mask 0x0F, value 0x01, count 2, pretrig 4 -> 0x01 ignored in PRE; 0x11 counts as 1st, trigger on 0x21; rd_addr 4 = 0x21, rd_addr 0 = 0x1D.
3. Edge vs level on a held input: data_i held 0x55 for 6 cycles then 0x00, repeated; mask 0xFF, value 0x55, count 2.
   - Edge mode fires on the first cycle of the second 0x55 run.
   - Level mode fires on the 2nd cycle of the first run.
4. sample_en gaps: sample_en toggles 1/0 and data_i increments every cycle -> only even-cycle values are stored; counters advance only on sampled cycles; readback shows stride-2 values.
5. Boundaries:
   - pretrig 0 -> trigger at rd_addr 0.
   - pretrig 15 -> DONE on the trigger cycle.
   - pretrig written as 15 with DEPTH=16 (clamp) -> same as pretrig 15.
   - trig_count 0 -> fires on the first hit.
6. Abort and reset: abort in POST -> IDLE next cycle, done_o = 0. arm+abort same cycle -> stays IDLE. rst_i in ARMED -> IDLE; re-arm completes scenario 1 correctly.
